// File: rtl/color_sensor_emu.sv
// Light-to-frequency colour sensor emulator.
// One programmable half period per filter, quiet settle after every filter change.
module color_sensor_emu #(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_HALF = 500,
  parameter int SETTLE       = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       select,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             wave,
  output logic             settling
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SETL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] SETTLE_M1 = WIDTH'(SETTLE - 1);
  localparam logic [WIDTH-1:0] HALF_RST  = WIDTH'(DEFAULT_HALF);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] scnt_q, scnt_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic             wave_q, wave_d;
  logic [WIDTH-1:0] half_q [4];
  logic [1:0]       sync_q;
  logic [1:0]       sels_q;
  logic [1:0]       selp_q;
  logic [WIDTH-1:0] hsel;
  logic             change;

  // Two-flop synchronizer for select plus a delayed copy for change detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'd0;
      sels_q <= 2'd0;
      selp_q <= 2'd0;
    end else begin
      sync_q <= select;
      sels_q <= sync_q;
      selp_q <= sels_q;
    end
  end

  assign change = (sels_q != selp_q);
  assign hsel   = half_q[sels_q];

  // Per-filter half-period registers, writable in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        half_q[i] <= HALF_RST;
      end
    end else if (cfg_we) begin
      half_q[cfg_addr] <= cfg_data;
    end
  end

  // State, counters, latched half period and wave level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scnt_q  <= '0;
      h_q     <= '0;
      wave_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      h_q     <= h_d;
      wave_q  <= wave_d;
    end
  end

  // Next-state: settle countdown, half-period reloads, restart and disable
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    h_d     = h_q;
    wave_d  = wave_q;

    unique case (state_q)
      IDLE: begin
        wave_d = 1'b0;
        cnt_d  = '0;
        scnt_d = '0;
        if (en) begin
          if (SETTLE == 0) begin
            state_d = RUN;
            h_d     = hsel;
          end else begin
            state_d = SETL;
          end
        end
      end
      SETL: begin
        wave_d = 1'b0;
        if (scnt_q == SETTLE_M1) begin
          state_d = RUN;
          cnt_d   = '0;
          scnt_d  = '0;
          h_d     = hsel;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      RUN: begin
        if (h_q == '0) begin
          // dark filter: hold low and keep re-reading the register
          wave_d = 1'b0;
          cnt_d  = '0;
          h_d    = hsel;
        end else if (cnt_q == h_q - 1'b1) begin
          cnt_d  = '0;
          h_d    = hsel;
          wave_d = (hsel == '0) ? 1'b0 : ~wave_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        wave_d  = 1'b0;
        cnt_d   = '0;
        scnt_d  = '0;
      end
    endcase

    if (state_q != IDLE && change) begin
      wave_d = 1'b0;
      cnt_d  = '0;
      scnt_d = '0;
      if (SETTLE == 0) begin
        state_d = RUN;
        h_d     = hsel;
      end else begin
        state_d = SETL;
      end
    end

    if (!en) begin
      state_d = IDLE;
      wave_d  = 1'b0;
      cnt_d   = '0;
      scnt_d  = '0;
    end
  end

  assign wave     = wave_q;
  assign settling = (state_q == SETL);

endmodule

// File: doc/color_sensor_emu.md
# color_sensor_emu

Emulates the light-to-frequency colour sensor that the colour-measurement path reads. It takes the 2-bit filter-select lines that colour detection drives and produces the sensor's square wave, with a separately programmable frequency for each filter. After every filter change it holds a quiet settling interval, as the real sensor does. The block sits on the bench/HIL side of the sensor interface, so the colour-detection logic can be exercised with known, repeatable frequencies instead of a physical sensor.

## Interface
Parameters:
- WIDTH, 16, width of half-period registers and counters
- DEFAULT_HALF, 500, reset value of all four half-period registers (clk cycles)
- SETTLE, 100, settle interval after enable or filter change (clk cycles, 0 allowed)

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  reset; asynchronous, active-high
- en  in  1  emulator enable, synchronous to clk
- select  in  2  filter select from colour detection, asynchronous to clk
- cfg_we  in  1  config write strobe, one cycle per write
- cfg_addr  in  2  half-period register index (equals filter code)
- cfg_data  in  WIDTH  half-period value in clk cycles
- wave  out  1  emulated sensor square wave
- settling  out  1  high while in SETTLE state

## Operation
- Reset values: wave=0, settling=0, state=IDLE, all counters 0, half[0..3]=DEFAULT_HALF, sync flops 0.
- select passes through a 2-flop synchronizer to give sel_s; sel_q is a registered copy of sel_s; change = (sel_s != sel_q).
- Config: when cfg_we=1, half[cfg_addr] <= cfg_data on that edge. Writes are accepted in every state. A write to the active filter takes effect at the next half-period reload and does not truncate the current half period.
- States:
  - IDLE: wave=0, counters cleared; en=1 -> SETTLE.
  - SETTLE: wave=0, settling=1; scnt counts edges; when scnt reaches SETTLE -> RUN with cnt=0. SETTLE=0 goes straight from IDLE to RUN.
  - RUN: on each edge cnt increments; when cnt == half[sel_s]-1, toggle wave and clear cnt (current H latched at reload).
- change=1 in SETTLE or RUN -> SETTLE on the next edge with wave=0 and scnt=0. This restarts an in-progress settle.
- en=0 in any state -> IDLE on the next edge; wave=0 at that edge.
- en=0 has priority over change.
- H=0 in RUN: wave is held 0 and cnt is held 0 ("dark" filter). A later nonzero write takes effect on the following edge.
- Counter widths: cnt and scnt are WIDTH bits and never wrap, because compare/reset happens first. SETTLE must fit in WIDTH.

## Timing
- Enable start: en sampled high at edge k -> SETTLE after edge k. RUN is entered at edge k+SETTLE, and wave rises at edge k+SETTLE+H.
- Steady state: wave high for H cycles, low for H cycles; period 2H, 50% duty.
- Select change: select changes before edge t -> sel_s updates at t+1 -> change is seen at t+2. wave=0 and settling=1 after edge t+2; the first rising edge comes at t+2+SETTLE+H.
- en deassert: wave=0 and settling=0 one edge after en is sampled low.
- rst: all outputs and registers go to reset values immediately, including mid-period and mid-settle. Config writes made before reset are lost.
- Simultaneous cfg_we and change: the write lands, and the new value is used by the RUN that follows settle.

## Test plan
- Reset/default: rst pulse, then en=1, select=0 held -> wave first rises 600 cycles after en is sampled, then period 1000 cycles with high time exactly 500; settling high for exactly 100 cycles.
- Per-filter frequency: write half[0..3]=10,20,40,80, step select 0→3 with each held 2000 cycles -> measured high/low times 10/20/40/80. Each change produces a 100-cycle low settle with settling=1.
- Mid-settle change: change select 50 cycles into a settle -> settle restarts, wave is low for ≥102 cycles after the select edge, then resumes at the new frequency.
- Live rewrite: in RUN with H=100, write half[sel]=30 at cnt≈40 -> current half period finishes at 100, next one is 30; no settle and settling stays 0.
- Dark and disable: write half[sel]=0 -> wave stuck 0; write 25 -> toggles every 25. Drop en mid-high -> wave=0 next edge and state IDLE.
- Async reset mid-run: assert rst between clk edges while wave=1 -> wave=0 and settling=0 immediately; half registers read back 500 behaviourally (period 1000 after re-enable).
